// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetches 17-bit instructions (op + signed arg), expands them
// into execution cycles and drives the signal-strength datapath with
// per-cycle execute, X-update and sample strobes plus CRT beam coordinates.
module cpu_sequencer #(
    parameter int ADDR_W       = 12,
    parameter int CYC_W        = 16,
    parameter int FIRST_SAMPLE = 20,
    parameter int SAMPLE_STEP  = 40,
    parameter int NUM_SAMPLES  = 6,
    parameter int MAX_CYCLES   = 240,
    parameter int CRT_W        = 40,
    parameter int CRT_H        = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [16:0]       imem_data,
    output logic              exec_en,
    output logic [CYC_W-1:0]  cycle,
    output logic              x_add_en,
    output logic [15:0]       x_arg,
    output logic              sample_en,
    output logic [CYC_W-1:0]  sample_weight,
    output logic [5:0]        beam_col,
    output logic [2:0]        beam_row,
    output logic              busy,
    output logic              done
);

    localparam int SMP_W = $clog2(NUM_SAMPLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] len;
    logic              instr_op;
    logic [15:0]       instr_arg;
    logic [CYC_W-1:0]  next_sample;
    logic [SMP_W-1:0]  samples;

    logic [CYC_W-1:0]  cycle_nxt;
    logic              sample_hit;
    logic              cap_hit;
    logic              issue;
    logic [5:0]        col_nxt;
    logic [2:0]        row_nxt;

    // Next-cycle arithmetic: saturating cycle count, sample match, cap, beam advance
    always_comb begin
        cycle_nxt  = (cycle == '1) ? cycle : cycle + CYC_W'(1);
        sample_hit = (samples < SMP_W'(NUM_SAMPLES)) && (cycle_nxt == next_sample);
        cap_hit    = (cycle >= CYC_W'(MAX_CYCLES));
        // An execution cycle starts on fetch completion or on an addx continuing past EXEC1
        issue      = ((state == S_FETCH) && imem_req && imem_valid) ||
                     ((state == S_EXEC1) && instr_op && !cap_hit);
        col_nxt    = beam_col + 6'd1;
        row_nxt    = beam_row;
        if (beam_col == 6'(CRT_W - 1)) begin
            col_nxt = '0;
            row_nxt = (beam_row == 3'(CRT_H - 1)) ? '0 : beam_row + 3'd1;
        end
    end

    // Sequencer FSM with registered strobes and datapath controls
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            pc            <= '0;
            len           <= '0;
            instr_op      <= 1'b0;
            instr_arg     <= '0;
            next_sample   <= '0;
            samples       <= '0;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            exec_en       <= 1'b0;
            cycle         <= '0;
            x_add_en      <= 1'b0;
            x_arg         <= '0;
            sample_en     <= 1'b0;
            sample_weight <= '0;
            beam_col      <= '0;
            beam_row      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            exec_en       <= 1'b0;
            x_add_en      <= 1'b0;
            x_arg         <= '0;
            sample_en     <= 1'b0;
            sample_weight <= '0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc          <= '0;
                        cycle       <= '0;
                        next_sample <= CYC_W'(FIRST_SAMPLE);
                        samples     <= '0;
                        beam_col    <= '0;
                        beam_row    <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        len         <= prog_len;
                        state       <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (!imem_req) begin
                        if (pc >= len) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end else if (imem_valid) begin
                        imem_req  <= 1'b0;
                        instr_op  <= imem_data[16];
                        instr_arg <= imem_data[15:0];
                        state     <= S_EXEC1;
                    end
                end

                S_EXEC1: begin
                    beam_col <= col_nxt;
                    beam_row <= row_nxt;
                    if (cap_hit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (instr_op) begin
                        x_add_en <= 1'b1;
                        x_arg    <= instr_arg;
                        state    <= S_EXEC2;
                    end else begin
                        pc    <= pc + ADDR_W'(1);
                        state <= S_FETCH;
                    end
                end

                S_EXEC2: begin
                    beam_col <= col_nxt;
                    beam_row <= row_nxt;
                    pc       <= pc + ADDR_W'(1);
                    if (cap_hit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                    end
                end

                default: state <= S_IDLE;
            endcase

            // Shared execution-cycle entry: strobe, count and sample check
            if (issue) begin
                exec_en <= 1'b1;
                cycle   <= cycle_nxt;
                if (sample_hit) begin
                    sample_en     <= 1'b1;
                    sample_weight <= cycle_nxt;
                    next_sample   <= next_sample + CYC_W'(SAMPLE_STEP);
                    samples       <= samples + SMP_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Control block that drives the Day 10 signal-strength datapath.
- Fetches 17-bit instruction words from instruction memory: bit 16 = op (1 = addx, 0 = noop), bits 15:0 = signed arg. Fetches use a req/valid handshake with variable latency.
- Expands each instruction into its execution cycles: noop = 1 cycle, addx = 2 cycles.
- Drives the datapath with per-cycle execute strobes, an X-update enable, sample strobes carrying the cycle weight, and CRT beam coordinates.

Parameters:
- ADDR_W, 12, instruction address width.
- CYC_W, 16, execution cycle counter width.
- FIRST_SAMPLE, 20, first sampled cycle number.
- SAMPLE_STEP, 40, spacing between sampled cycles.
- NUM_SAMPLES, 6, number of sample strobes per run.
- MAX_CYCLES, 240, hard cap on execution cycles per run.
- CRT_W, 40, beam columns per row.
- CRT_H, 6, beam rows.

Ports:
- CLK  in  1  system clock (16 MHz).
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from address 0.
- prog_len  in  ADDR_W  number of instructions in the program; sampled on start.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_valid  in  1  fetch data valid.
- imem_data  in  17  instruction word.
- exec_en  out  1  high for exactly one clock per execution cycle.
- cycle  out  CYC_W  1-based number of the current execution cycle.
- x_add_en  out  1  datapath adds x_arg to X at the end of this clock.
- x_arg  out  16  addx argument.
- sample_en  out  1  datapath accumulates X*sample_weight.
- sample_weight  out  CYC_W  equals cycle when sample_en is high.
- beam_col  out  6  CRT column for the current execution cycle.
- beam_row  out  3  CRT row for the current execution cycle.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or RST.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including imem_req, the cycle counter, the beam position, the sample counter and pc.
  - Reset overrides everything, including reset in the middle of a fetch or in EXEC2: no x_add_en is issued for the aborted instruction.
- States: IDLE, FETCH, EXEC1, EXEC2, DONE.
- IDLE / DONE on start:
  - pc=0, cycle=0, next_sample=FIRST_SAMPLE, samples=0, beam=(0,0), done=0, busy=1.
  - Latch prog_len, then go to FETCH.
  - start is ignored while busy.
- FETCH:
  - If pc >= latched prog_len, go to DONE without asserting imem_req.
  - Otherwise assert imem_req with imem_addr=pc. Both are held stable until imem_valid is seen.
  - On imem_valid: latch imem_data, drop imem_req on the next clock, go to EXEC1.
  - imem_valid without req is ignored.
  - While waiting for imem_valid: no exec_en and no cycle increment, so cycle numbers stay contiguous across fetch stalls.
- EXEC1 (one clock):
  - exec_en=1, cycle = previous+1.
  - Sample check (below).
  - noop: pc+1, go to FETCH.
  - addx: go to EXEC2.
- EXEC2 (one clock):
  - exec_en=1, cycle = previous+1.
  - Sample check.
  - x_add_en=1 and x_arg=arg in this same clock. X therefore changes after cycle 2 of the addx; the sample in this clock sees the pre-update X.
  - pc+1, go to FETCH.
- Sample check:
  - When samples < NUM_SAMPLES and cycle == next_sample: sample_en=1, sample_weight=cycle, next_sample += SAMPLE_STEP, samples+1.
  - sample_en and x_add_en may both be high in the same clock; the datapath samples old X.
- Beam:
  - The values shown with an exec_en are the position for that cycle; they advance after it.
  - col wraps from CRT_W-1 to 0 and increments row; row wraps from CRT_H-1 to 0.
- Cycle cap:
  - When the exec cycle numbered MAX_CYCLES completes, go to DONE, even mid-addx.
  - If this cuts an addx after EXEC1, no x_add_en is issued.
- DONE: busy=0, done=1, all strobes 0. A new start restarts the run.
- Arithmetic:
  - arg is two's complement; it is passed through unchanged.
  - The cycle counter saturates at its maximum and never wraps (MAX_CYCLES < 2^CYC_W).
- Strobes (exec_en, x_add_en, sample_en) are registered and single-cycle. They are never asserted outside EXEC1/EXEC2.

Test Plan:
- prog noop, addx 3, addx -5 with zero-wait memory, prog_len=3 -> exec_en at cycles 1..5; x_add_en at cycle 3 (x_arg=0x0003) and at cycle 5 (x_arg=0xFFFB); done one clock after the last fetch check; no sample_en.
- Standard 146-instruction example program -> sample_en exactly 6 times, sample_weight = 20, 60, 100, 140, 180, 220; with the team datapath, sig = 13140; run stops at cycle 240 (cap) with done=1.
- imem_valid delayed 0/3/7 clocks randomly -> imem_req and imem_addr stable while waiting; no exec_en during stalls; cycle numbers gap-free; same x_add_en sequence as the zero-wait run.
- prog_len=0, start -> DONE within 2 clocks, imem_req never asserted, exec_en never asserted.
- RST pulsed during EXEC1 of an addx -> no x_add_en; all outputs 0 next clock; a subsequent start reruns from addr 0 with cycle restarting at 1.
- 240 noops -> beam goes (39,0)->(0,1) at cycles 40/41 and (39,5) at cycle 240; start pulses asserted mid-run are ignored.
